// File: rtl/hdmi_audio_pkg.sv
// Shared types and constants for the HDMI audio scheduler.
package hdmi_audio_pkg;

  typedef enum logic [2:0] {
    MUTED,
    PRIMING,
    ARMED,
    RUNNING,
    FLUSH
  } state_t;

  localparam logic [7:0] UNDERRUN_MAX = 8'd255;

  // Accumulator width: holds values up to 2*CLK_FREQ_HZ without overflow.
  function automatic int acc_width(input int clk_freq_hz);
    return $clog2(clk_freq_hz) + 2;
  endfunction

endpackage

// File: rtl/hdmi_audio_scheduler_if.sv
// Producer sample stream into the scheduler.
// Handshake: a sample transfers on a rising clock edge where s_valid and
// s_ready are both 1; the producer holds s_left/s_right stable while s_valid
// is high, and s_ready never depends on s_valid.
interface hdmi_audio_scheduler_if #(
  parameter int W = 16
) ();
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_left;
  logic [W-1:0] s_right;

  modport master (output s_valid, output s_left, output s_right, input s_ready);
  modport slave  (input s_valid, input s_left, input s_right, output s_ready);
endinterface

// File: rtl/hdmi_audio_scheduler_fifo.sv
// Small synchronous FIFO of packed {right,left} samples with a registered
// read port. rd_data holds its value when no pop occurs, which gives the
// scheduler its hold-last-word behaviour on underrun for free.
module audio_sample_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic                     clear,
  input  logic [2*W-1:0]           wr_data,
  output logic [2*W-1:0]           rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [2*W-1:0] mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  // Storage array; no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and the registered read word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (clear) rd_data <= '0;
      else if (do_pop) rd_data <= mem[rd_ptr];
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end
endmodule

// File: rtl/hdmi_audio_scheduler.sv
// Paces audio into the HDMI output block: fractional accumulator generates
// clk_audio from clk_pixel, a FIFO buffers producer samples, and a small FSM
// gates include_audio on frame boundaries. The word changes only when
// clk_audio falls so it is stable at the rising edge the HDMI core samples.
module hdmi_audio_scheduler
  import hdmi_audio_pkg::*;
#(
  parameter int CLK_FREQ_HZ     = 25_200_000,
  parameter int AUDIO_RATE      = 44100,
  parameter int AUDIO_BIT_WIDTH = 16,
  parameter int FIFO_DEPTH      = 4,
  parameter int PRIME_LEVEL     = 2
) (
  input  logic                       clk_pixel,
  input  logic                       reset,
  input  logic                       audio_enable,
  input  logic                       frame_start,
  hdmi_audio_scheduler_if.slave      s,
  output logic                       clk_audio,
  output logic [AUDIO_BIT_WIDTH-1:0] audio_sample_word [2],
  output logic                       include_audio,
  output logic [7:0]                 underrun_count,
  output state_t                     state
);
  localparam int ACC_W = acc_width(CLK_FREQ_HZ);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ACC_W-1:0] STEP  = ACC_W'(2 * AUDIO_RATE);
  localparam logic [ACC_W-1:0] LIMIT = ACC_W'(CLK_FREQ_HZ);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic             wrap;
  logic             fall_tick;

  state_t           next_state;
  logic             stop_pending;
  logic             next_stop;
  logic             next_include;
  logic [7:0]       next_under;

  logic             push;
  logic             pop;
  logic             flush;
  logic             clear;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic [2*AUDIO_BIT_WIDTH-1:0] rd_data;

  assign sum       = acc + STEP;
  assign wrap      = (sum >= LIMIT);
  assign fall_tick = wrap && clk_audio;

  assign s.s_ready = !reset && !full && (state != FLUSH);
  assign push      = s.s_valid && s.s_ready;

  assign audio_sample_word[0] = rd_data[AUDIO_BIT_WIDTH-1:0];
  assign audio_sample_word[1] = rd_data[2*AUDIO_BIT_WIDTH-1:AUDIO_BIT_WIDTH];

  // Fractional clock divider; runs in every state so clk_audio never stops.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      acc       <= '0;
      clk_audio <= 1'b0;
    end else begin
      acc <= wrap ? (sum - LIMIT) : sum;
      if (wrap) clk_audio <= ~clk_audio;
    end
  end

  audio_sample_fifo #(
    .W     (AUDIO_BIT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_pixel),
    .rst     (reset),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .clear   (clear),
    .wr_data ({s.s_right, s.s_left}),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Scheduler state and its registered outputs.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state          <= MUTED;
      include_audio  <= 1'b0;
      stop_pending   <= 1'b0;
      underrun_count <= '0;
    end else begin
      state          <= next_state;
      include_audio  <= next_include;
      stop_pending   <= next_stop;
      underrun_count <= next_under;
    end
  end

  // Next-state and FIFO control decisions.
  always_comb begin
    next_state   = state;
    next_include = include_audio;
    next_stop    = stop_pending;
    next_under   = underrun_count;
    pop          = 1'b0;
    clear        = 1'b0;
    flush        = 1'b0;
    case (state)
      MUTED: begin
        if (fall_tick) clear = 1'b1;
        if (audio_enable) next_state = PRIMING;
      end
      PRIMING: begin
        if (!audio_enable) next_state = FLUSH;
        else if (count >= CW'(PRIME_LEVEL)) next_state = ARMED;
      end
      ARMED: begin
        if (!audio_enable) next_state = FLUSH;
        else if (frame_start) begin
          next_include = 1'b1;
          next_state   = RUNNING;
        end
      end
      RUNNING: begin
        if (fall_tick) begin
          if (!empty) pop = 1'b1;
          else if (underrun_count != UNDERRUN_MAX) next_under = underrun_count + 8'd1;
        end
        // Stopping waits for a frame boundary so the HDMI core never sees
        // audio switched off mid-frame.
        if (frame_start && stop_pending) begin
          next_include = 1'b0;
          next_stop    = 1'b0;
          next_state   = FLUSH;
        end else if (!audio_enable) begin
          next_stop = 1'b1;
        end
      end
      FLUSH: begin
        flush      = 1'b1;
        next_state = MUTED;
      end
      default: next_state = MUTED;
    endcase
  end
endmodule
